// File: rtl/lane_pattern_checker.sv
// Receive-side checker for the lane-vector test path.
// Compares each accepted beat against a ramp pattern and tallies mismatches.
module lane_pattern_checker #(
  parameter int NUM_LANES = 3,
  parameter int WIDTH     = 32,
  parameter int NUM_BEATS = 4,
  parameter int BASE      = 1,
  parameter int CNT_W     = 8,
  localparam int BW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_start,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [NUM_LANES*WIDTH-1:0] io_in_data,
  output logic                       io_busy,
  output logic                       io_done,
  output logic                       io_pass,
  output logic [CNT_W-1:0]           io_err_count,
  output logic [BW-1:0]              io_fail_beat,
  output logic [LW-1:0]              io_fail_lane,
  output logic [WIDTH-1:0]           io_fail_data
);

  localparam int MCW = $clog2(NUM_LANES + 1);
  localparam int SW  = CNT_W + MCW + 1;

  typedef enum logic [1:0] {
    Idle,
    Run,
    Done
  } state_t;

  state_t            state;
  logic [BW-1:0]     beatCnt;
  logic              accept;
  logic              lastBeat;
  logic [NUM_LANES-1:0] mismatch;
  logic [MCW-1:0]    hits;
  logic [SW-1:0]     errSum;
  logic [CNT_W-1:0]  errNext;
  logic [LW-1:0]     firstLane;
  logic [WIDTH-1:0]  firstData;
  logic [WIDTH-1:0]  laneData;
  logic [WIDTH-1:0]  expLane;

  always_comb begin
    accept    = (state == Run) && io_in_valid;
    lastBeat  = (beatCnt == BW'(NUM_BEATS - 1));
    mismatch  = '0;
    hits      = '0;
    firstLane = '0;
    firstData = '0;
    laneData  = '0;
    expLane   = '0;
    // Walk lanes high to low so the lowest mismatch wins.
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      laneData = io_in_data[l*WIDTH +: WIDTH];
      expLane  = WIDTH'(BASE)
               + WIDTH'(beatCnt) * WIDTH'(NUM_LANES)
               + WIDTH'(l);
      if (laneData != expLane) begin
        mismatch[l] = 1'b1;
        firstLane   = LW'(l);
        firstData   = laneData;
      end
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      hits = hits + MCW'(mismatch[l]);
    end
    errSum = SW'(io_err_count) + SW'(hits);
    if (errSum > SW'({CNT_W{1'b1}})) begin
      errNext = {CNT_W{1'b1}};
    end else begin
      errNext = errSum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= Idle;
      beatCnt      <= '0;
      io_in_ready  <= 1'b0;
      io_busy      <= 1'b0;
      io_done      <= 1'b0;
      io_pass      <= 1'b0;
      io_err_count <= '0;
      io_fail_beat <= '0;
      io_fail_lane <= '0;
      io_fail_data <= '0;
    end else begin
      unique case (1'b1)
        (state == Idle), (state == Done): begin
          if (io_start) begin
            state        <= Run;
            beatCnt      <= '0;
            io_in_ready  <= 1'b1;
            io_busy      <= 1'b1;
            io_done      <= 1'b0;
            io_pass      <= 1'b0;
            io_err_count <= '0;
            io_fail_beat <= '0;
            io_fail_lane <= '0;
            io_fail_data <= '0;
          end
        end
        (state == Run): begin
          if (accept) begin
            io_err_count <= errNext;
            // A zero count means no earlier beat of this run failed.
            if (io_err_count == '0 && |mismatch) begin
              io_fail_beat <= beatCnt;
              io_fail_lane <= firstLane;
              io_fail_data <= firstData;
            end
            if (lastBeat) begin
              state       <= Done;
              beatCnt     <= '0;
              io_in_ready <= 1'b0;
              io_busy     <= 1'b0;
              io_done     <= 1'b1;
              io_pass     <= (errNext == '0);
            end else begin
              beatCnt <= beatCnt + BW'(1);
            end
          end
        end
        default: begin
          state <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_pattern_checker.sv
// Randomized scoreboard bench for lane_pattern_checker.
// Two instances share stimulus: default counter width and a 2-bit one.
module tb_lane_pattern_checker;

  localparam int NL = 3;
  localparam int W  = 32;
  localparam int NB = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          io_start = 1'b0;
  logic          io_in_valid = 1'b0;
  logic [NL*W-1:0] io_in_data = '0;

  logic       aReady, aBusy, aDone, aPass;
  logic [7:0] aErr;
  logic [1:0] aBeat, aLane;
  logic [W-1:0] aData;
  logic       bReady, bBusy, bDone, bPass;
  logic [1:0] bErr;
  logic [1:0] bBeat, bLane;
  logic [W-1:0] bData;

  lane_pattern_checker dutA (
    .clock(clock), .reset(reset), .io_start(io_start),
    .io_in_valid(io_in_valid), .io_in_ready(aReady),
    .io_in_data(io_in_data), .io_busy(aBusy),
    .io_done(aDone), .io_pass(aPass), .io_err_count(aErr),
    .io_fail_beat(aBeat), .io_fail_lane(aLane),
    .io_fail_data(aData)
  );

  lane_pattern_checker #(.CNT_W(2)) dutB (
    .clock(clock), .reset(reset), .io_start(io_start),
    .io_in_valid(io_in_valid), .io_in_ready(bReady),
    .io_in_data(io_in_data), .io_busy(bBusy),
    .io_done(bDone), .io_pass(bPass), .io_err_count(bErr),
    .io_fail_beat(bBeat), .io_fail_lane(bLane),
    .io_fail_data(bData)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         errs;
    int         fb;
    int         fl;
    logic [W-1:0] fd;
  } exp_t;

  exp_t sbq[$];
  exp_t lastExp;
  logic [W-1:0] data [NB][NL];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] expv(input int b, input int l);
    return W'(1 + b * NL + l);
  endfunction

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.errs = 0; e.fb = 0; e.fl = 0; e.fd = '0;
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < NL; l++)
        if (data[b][l] != expv(b, l)) begin
          if (e.errs == 0) begin
            e.fb = b; e.fl = l; e.fd = data[b][l];
          end
          e.errs++;
        end
    return e;
  endfunction

  task automatic fillGood();
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < NL; l++)
        data[b][l] = expv(b, l);
  endtask

  task automatic fillRandom(input int pErr);
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < NL; l++) begin
        data[b][l] = expv(b, l);
        if ($urandom_range(99) < pErr)
          data[b][l] = data[b][l] ^ ($urandom() | 32'h1);
      end
  endtask

  task automatic chkZero(input string nm);
    chk({nm, " readyA"}, 64'(aReady), 0);
    chk({nm, " busyA"}, 64'(aBusy), 0);
    chk({nm, " doneA"}, 64'(aDone), 0);
    chk({nm, " passA"}, 64'(aPass), 0);
    chk({nm, " errA"}, 64'(aErr), 0);
    chk({nm, " failA"}, {aBeat, aLane, aData}, 0);
    chk({nm, " errB"}, 64'(bErr), 0);
  endtask

  task automatic idleNoise(input int n, input bit inDone);
    for (int i = 0; i < n; i++) begin
      io_in_valid = 1'b1;
      io_in_data  = {$urandom(), $urandom(), $urandom()};
      @(negedge clock);
      chk("idle ready", 64'(aReady), 0);
      chk("idle done", 64'(aDone), 64'(inDone));
      if (inDone)
        chk("done err stable", 64'(aErr),
            64'(sat(lastExp.errs, 255)));
      else
        chk("idle err", 64'(aErr), 0);
    end
    io_in_valid = 1'b0;
  endtask

  task automatic doRun(input bit gaps, input bit noise,
                       input int abortAt);
    exp_t e;
    int b;
    bit acc;
    e = model();
    io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
    chk("run busy", 64'(aBusy), 1);
    chk("run ready", 64'(aReady), 1);
    chk("run cleared err", {aErr, 6'd0, bErr}, 0);
    chk("run cleared fail", {aBeat, aLane, aData}, 0);
    chk("run done", 64'(aDone), 0);
    b = 0;
    while (b < NB) begin
      if (gaps && $urandom_range(2) == 0) begin
        io_in_valid = 1'b0;
        io_in_data  = {$urandom(), $urandom(), $urandom()};
      end else begin
        io_in_valid = 1'b1;
        for (int l = 0; l < NL; l++)
          io_in_data[l*W +: W] = data[b][l];
        if (b == NB - 1) sbq.push_back(e);
      end
      io_start = noise ? 1'($urandom_range(1)) : 1'b0;
      acc = io_in_valid && aReady;
      @(negedge clock);
      if (acc) b++;
      if (b == abortAt) break;
    end
    io_in_valid = 1'b0;
    io_start = 1'b0;
    if (b == abortAt) begin
      reset = 1'b0;
      #1;
      chkZero("async reset");
      @(negedge clock);
      reset = 1'b1;
      chkZero("after reset");
      idleNoise(3, 1'b0);
    end else begin
      lastExp = e;
      chk("done latency", 64'(aDone), 1);
      chk("done ready", 64'(aReady), 0);
      chk("done busy", 64'(aBusy), 0);
    end
  endtask

  // Monitor: compare results on each rising edge of done.
  initial begin
    exp_t e;
    logic prevDone;
    prevDone = 1'b0;
    forever begin
      @(negedge clock);
      if (aDone && !prevDone) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb: done with no expected entry");
        end else begin
          e = sbq.pop_front();
          chk("errA", 64'(aErr), 64'(sat(e.errs, 255)));
          chk("errB", 64'(bErr), 64'(sat(e.errs, 3)));
          chk("passA", 64'(aPass), 64'(e.errs == 0));
          chk("passB", 64'(bPass), 64'(e.errs == 0));
          chk("failBeat", {aBeat, bBeat}, {2'(e.fb), 2'(e.fb)});
          chk("failLane", {aLane, bLane}, {2'(e.fl), 2'(e.fl)});
          chk("failData", {aData, bData}, {e.fd, e.fd});
        end
      end
      prevDone = aDone;
    end
  end

  initial begin
    #1;
    chkZero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    idleNoise(2, 1'b0);
    fillGood();
    doRun(1'b0, 1'b0, -1);
    idleNoise(2, 1'b1);
    fillGood();
    data[2][1] = 32'd99;
    data[2][2] = 32'd99;
    doRun(1'b0, 1'b0, -1);
    fillGood();
    doRun(1'b1, 1'b0, -1);
    fillRandom(30);
    doRun(1'b0, 1'b1, -1);
    fillRandom(30);
    doRun(1'b0, 1'b0, 2);
    fillGood();
    doRun(1'b0, 1'b0, -1);
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < NL; l++)
        data[b][l] = expv(b, l) + 32'd100;
    doRun(1'b0, 1'b0, -1);
    for (int r = 0; r < 25; r++) begin
      fillRandom($urandom_range(0, 3) * 15);
      doRun(1'($urandom_range(1)), 1'($urandom_range(1)), -1);
      if ($urandom_range(1) == 1) idleNoise(2, 1'b1);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb: %0d results never reported, 0 required",
               sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
